l1_cache_controller: RTL

Blocking, write-back, write-allocate L1 controller. It initiates every operation on port 0 of the set-associative tag/data array and turns single-word core requests into lookup, writeback, fill and update sequences against a block-wide next-level memory.
// It sits between the core memory stage and the cache array plus next-level memory. The array's port 1 is tied off by the enclosing level.

---
 rtl/l1_cache_controller.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/l1_cache_controller.sv
// l1_cache_controller
// Blocking, write-back, write-allocate L1 controller driving port 0 of a
// set-associative tag/data array and a block-wide next-level memory.
// Optional build macro: L1_CACHE_EARLY_RESTART_EN
//   defined   -> a read miss returns its word in the UPDATE cycle
//   undefined -> every miss completes after UPDATE
module l1_cache_controller #(
    parameter int ADDRESS_BITS   = 32,
    parameter int INDEX_BITS     = 8,
    parameter int OFFSET_BITS    = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int NUMBER_OF_WAYS = 4,
    parameter int STATUS_BITS    = 2,
    parameter int COHERENCE_BITS = 2,
    localparam int TAG_BITS      = ADDRESS_BITS - INDEX_BITS - OFFSET_BITS,
    localparam int WORDS         = 1 << OFFSET_BITS,
    localparam int BLOCK         = DATA_WIDTH * WORDS,
    localparam int WAY_BITS      = (NUMBER_OF_WAYS > 1) ? $clog2(NUMBER_OF_WAYS) : 1,
    localparam int META_BITS     = STATUS_BITS + COHERENCE_BITS
) (
    input  logic                    clock,
    input  logic                    reset,
    // core side
    input  logic                    read,
    input  logic                    write,
    input  logic [ADDRESS_BITS-1:0] address,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic                    ready,
    output logic                    valid,
    output logic [DATA_WIDTH-1:0]   data_out,
    // cache array port 0
    output logic                    read0,
    output logic                    write0,
    output logic [INDEX_BITS-1:0]   index0,
    output logic [TAG_BITS-1:0]     tag0,
    output logic [META_BITS-1:0]    meta_data0,
    output logic [BLOCK-1:0]        data_in0,
    output logic [WAY_BITS-1:0]     way_select0,
    input  logic [BLOCK-1:0]        data_out0,
    input  logic [TAG_BITS-1:0]     tag_out0,
    input  logic [WAY_BITS-1:0]     matched_way0,
    input  logic [STATUS_BITS-1:0]  status_bits0,
    input  logic                    hit0,
    // next-level memory
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [ADDRESS_BITS-1:0] mem_address,
    output logic [BLOCK-1:0]        mem_data_out,
    input  logic [BLOCK-1:0]        mem_data_in,
    input  logic                    mem_ready
);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        FILL,
        UPDATE
    } state_t;

    state_t                  state;

    // request latched on acceptance
    logic                    op_write;
    logic [TAG_BITS-1:0]     req_tag;
    logic [INDEX_BITS-1:0]   req_index;
    logic [OFFSET_BITS-1:0]  req_offset;
    logic [DATA_WIDTH-1:0]   req_data;

    // victim captured on a miss, fill line captured from memory
    logic [WAY_BITS-1:0]     victim_way;
    logic [TAG_BITS-1:0]     victim_tag;
    logic [BLOCK-1:0]        victim_line;
    logic [BLOCK-1:0]        fill_line;

    logic [TAG_BITS-1:0]     addr_tag;
    logic [INDEX_BITS-1:0]   addr_index;
    logic [OFFSET_BITS-1:0]  addr_offset;
    logic [STATUS_BITS-1:0]  status_w;
    logic                    victim_needs_writeback;

    assign addr_tag    = address[ADDRESS_BITS-1 -: TAG_BITS];
    assign addr_index  = address[OFFSET_BITS +: INDEX_BITS];
    assign addr_offset = address[OFFSET_BITS-1:0];

    assign victim_needs_writeback = status_bits0[STATUS_BITS-1] & status_bits0[STATUS_BITS-2];

    assign ready = (state == IDLE);

    function automatic logic [DATA_WIDTH-1:0] select_word(
        input logic [BLOCK-1:0]       line,
        input logic [OFFSET_BITS-1:0] off
    );
        return line[int'(off) * DATA_WIDTH +: DATA_WIDTH];
    endfunction

    function automatic logic [BLOCK-1:0] merge_word(
        input logic [BLOCK-1:0]       line,
        input logic [OFFSET_BITS-1:0] off,
        input logic [DATA_WIDTH-1:0]  word
    );
        logic [BLOCK-1:0] result;
        result = line;
        result[int'(off) * DATA_WIDTH +: DATA_WIDTH] = word;
        return result;
    endfunction

    // Array and memory strobes decoded from the current state; in reset the
    // address-driven lookup strobe is forced low so every output reads idle at once.
    always_comb begin
        read0        = 1'b0;
        write0       = 1'b0;
        index0       = req_index;
        tag0         = req_tag;
        data_in0     = '0;
        way_select0  = '0;
        status_w     = '0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_address  = '0;
        mem_data_out = '0;
        case (state)
            IDLE: begin
                read0  = read | write;
                index0 = addr_index;
                tag0   = addr_tag;
            end
            LOOKUP: begin
                if (hit0 && op_write) begin
                    write0                   = 1'b1;
                    way_select0              = matched_way0;
                    data_in0                 = merge_word(data_out0, req_offset, req_data);
                    status_w[STATUS_BITS-1]  = 1'b1;
                    status_w[STATUS_BITS-2]  = 1'b1;
                end
            end
            WRITEBACK: begin
                mem_write    = 1'b1;
                mem_address  = {victim_tag, req_index, {OFFSET_BITS{1'b0}}};
                mem_data_out = victim_line;
            end
            FILL: begin
                mem_read    = 1'b1;
                mem_address = {req_tag, req_index, {OFFSET_BITS{1'b0}}};
            end
            UPDATE: begin
                write0                   = 1'b1;
                way_select0              = victim_way;
                data_in0                 = op_write ? merge_word(fill_line, req_offset, req_data) : fill_line;
                status_w[STATUS_BITS-1]  = 1'b1;
                status_w[STATUS_BITS-2]  = op_write;
            end
            default: ;
        endcase
        if (!reset) begin
            read0  = 1'b0;
            index0 = '0;
            tag0   = '0;
        end
        meta_data0 = {status_w, {COHERENCE_BITS{1'b0}}};
    end

    // Controller sequencing: accept, look up, evict if dirty, fill, install.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            op_write    <= 1'b0;
            req_tag     <= '0;
            req_index   <= '0;
            req_offset  <= '0;
            req_data    <= '0;
            victim_way  <= '0;
            victim_tag  <= '0;
            victim_line <= '0;
            fill_line   <= '0;
            valid       <= 1'b0;
            data_out    <= '0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (read || write) begin
                        op_write   <= write;
                        req_tag    <= addr_tag;
                        req_index  <= addr_index;
                        req_offset <= addr_offset;
                        req_data   <= data_in;
                        state      <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit0) begin
                        if (!op_write) begin
                            data_out <= select_word(data_out0, req_offset);
                        end
                        valid <= 1'b1;
                        state <= IDLE;
                    end else begin
                        victim_way  <= matched_way0;
                        victim_tag  <= tag_out0;
                        victim_line <= data_out0;
                        state       <= victim_needs_writeback ? WRITEBACK : FILL;
                    end
                end
                WRITEBACK: begin
                    if (mem_ready) begin
                        state <= FILL;
                    end
                end
                FILL: begin
                    if (mem_ready) begin
                        fill_line <= mem_data_in;
                        state     <= UPDATE;
`ifdef L1_CACHE_EARLY_RESTART_EN
                        if (!op_write) begin
                            data_out <= select_word(mem_data_in, req_offset);
                            valid    <= 1'b1;
                        end
`endif
                    end
                end
                UPDATE: begin
                    state <= IDLE;
`ifdef L1_CACHE_EARLY_RESTART_EN
                    if (op_write) begin
                        valid <= 1'b1;
                    end
`else
                    valid <= 1'b1;
                    if (!op_write) begin
                        data_out <= select_word(fill_line, req_offset);
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
